mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between instruction fetch (IF) and data memory (DM) requesters.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data memory.
// DM has priority unless IF has waited STARVE_MAX cycles; a grant timeout forces completion.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  output logic              sel_o,
  output logic              stall_if_o,
  output logic              stall_dm_o,
  output logic              err_o
);

  localparam int unsigned WaitW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TcntW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StGntIf, StGntDm} state_e;

  state_e             state_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic [TcntW-1:0]   tcnt_q;

  logic granted;
  logic timeout_hit;
  logic done;
  logic starved;
  logic if_wins;
  logic wait_sat;

  assign granted     = (state_q != StIdle);
  assign timeout_hit = granted & ~mem_ack_i & (tcnt_q == TcntW'(TIMEOUT - 1));
  // Reset aborts the transaction, so no completion is reported in the reset cycle.
  assign done        = granted & (mem_ack_i | timeout_hit) & ~rst_i;
  assign if_ack_o    = done & (state_q == StGntIf);
  assign dm_ack_o    = done & (state_q == StGntDm);
  assign stall_if_o  = if_req_i & ~if_ack_o;
  assign stall_dm_o  = dm_req_i & ~dm_ack_o;

  assign wait_sat = (32'(wait_cnt_q) >= STARVE_MAX);
  assign starved  = wait_sat;
  assign if_wins  = if_req_i & (~dm_req_i | starved);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      tcnt_q      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      sel_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if ((state_q == StIdle) && if_wins) begin
        wait_cnt_q <= '0;
      end else if (if_req_i && (state_q != StGntIf) && !wait_sat) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (if_wins) begin
            state_q    <= StGntIf;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
            sel_o      <= 1'b0;
            tcnt_q     <= '0;
          end else if (dm_req_i) begin
            state_q     <= StGntDm;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            sel_o       <= 1'b1;
            tcnt_q      <= '0;
          end
        end
        StGntIf, StGntDm: begin
          if (mem_ack_i || timeout_hit) begin
            state_q   <= StIdle;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (timeout_hit) begin
              err_o <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario with inline expected values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic        sel_o;
  logic        stall_if_o;
  logic        stall_dm_o;
  logic        err_o;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (15)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ack_o   (dm_ack_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .sel_o      (sel_o),
    .stall_if_o (stall_if_o),
    .stall_dm_o (stall_dm_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Inputs for a cycle are applied 1 ns after its rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    vecs++;
    if ({mem_req_o, mem_we_o, sel_o, err_o} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req_o, mem_we_o, sel_o, err_o});
    end
    vecs++;
    if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin
      errs++; $display("FAIL reset_data: got %h/%h want 0/0", mem_addr_o, mem_wdata_o);
    end
    vecs++;
    if ({if_ack_o, dm_ack_o, stall_if_o, stall_dm_o} !== 4'b0000) begin
      errs++; $display("FAIL reset_ack: got %b want 0000",
                       {if_ack_o, dm_ack_o, stall_if_o, stall_dm_o});
    end
  endtask

  task automatic test_if_single();
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #1;
    vecs++;
    if ({mem_req_o, stall_if_o, if_ack_o} !== 3'b010) begin
      errs++; $display("FAIL t1_cyc0: got %b want 010", {mem_req_o, stall_if_o, if_ack_o});
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 2) if_addr_i = 32'h99;  // must not disturb the latched address
      mem_ack_i = (c == 3);
      #1;
      vecs++;
      if ({mem_req_o, sel_o, mem_we_o, mem_addr_o} !== {3'b100, 32'h40}) begin
        errs++; $display("FAIL t1_gnt_cyc%0d: got req=%b sel=%b we=%b addr=%h want 1 0 0 40",
                         c, mem_req_o, sel_o, mem_we_o, mem_addr_o);
      end
      vecs++;
      if ({if_ack_o, stall_if_o} !== ((c == 3) ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL t1_ack_cyc%0d: got ack=%b stall=%b", c, if_ack_o, stall_if_o);
      end
    end
    tick();
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    vecs++;
    if ({mem_req_o, if_ack_o, sel_o, mem_addr_o} !== {3'b000, 32'h40}) begin
      errs++; $display("FAIL t1_cyc4: got req=%b ack=%b sel=%b addr=%h want 0 0 0 40",
                       mem_req_o, if_ack_o, sel_o, mem_addr_o);
    end
  endtask

  task automatic test_dm_priority();
    if_req_i = 1'b1; if_addr_i = 32'h200;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b1;
    #1;
    vecs++;
    if ({mem_req_o, sel_o, mem_we_o, mem_addr_o, mem_wdata_o} !==
        {3'b111, 32'h100, 32'hDEADBEEF}) begin
      errs++; $display("FAIL t2_dm_gnt: got req=%b sel=%b we=%b addr=%h wdata=%h",
                       mem_req_o, sel_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    vecs++;
    if ({dm_ack_o, if_ack_o, stall_dm_o, stall_if_o} !== 4'b1001) begin
      errs++; $display("FAIL t2_dm_ack: got %b want 1001",
                       {dm_ack_o, if_ack_o, stall_dm_o, stall_if_o});
    end
    tick();
    dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    vecs++;
    if ({mem_req_o, dm_ack_o, if_ack_o} !== 3'b000) begin
      errs++; $display("FAIL t2_idle: got %b want 000", {mem_req_o, dm_ack_o, if_ack_o});
    end
    tick();
    mem_ack_i = 1'b1;
    #1;
    vecs++;
    if ({mem_req_o, sel_o, mem_we_o, mem_addr_o, if_ack_o} !== {3'b100, 32'h200, 1'b1}) begin
      errs++; $display("FAIL t2_if_gnt: got req=%b sel=%b we=%b addr=%h ack=%b",
                       mem_req_o, sel_o, mem_we_o, mem_addr_o, if_ack_o);
    end
    tick();
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
  endtask

  task automatic test_starvation();
    logic [4:0] exp_req;
    logic [4:0] exp_sel;
    logic [4:0] exp_dm_ack;
    logic [4:0] exp_if_ack;
    // Bit k-1 holds the expectation for cycle k.
    exp_req    = 5'b10101;
    exp_sel    = 5'b01111;
    exp_dm_ack = 5'b00101;
    exp_if_ack = 5'b10000;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    mem_ack_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      vecs++;
      if ({mem_req_o, sel_o} !== {exp_req[c-1], exp_sel[c-1]}) begin
        errs++; $display("FAIL t3_cyc%0d_grant: got req=%b sel=%b want %b %b",
                         c, mem_req_o, sel_o, exp_req[c-1], exp_sel[c-1]);
      end
      vecs++;
      if ({dm_ack_o, if_ack_o} !== {exp_dm_ack[c-1], exp_if_ack[c-1]}) begin
        errs++; $display("FAIL t3_cyc%0d_ack: got dm=%b if=%b want %b %b",
                         c, dm_ack_o, if_ack_o, exp_dm_ack[c-1], exp_if_ack[c-1]);
      end
    end
    vecs++;
    if (mem_addr_o !== 32'h400) begin
      errs++; $display("FAIL t3_if_addr: got %h want 400", mem_addr_o);
    end
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
    for (int c = 1; c <= 15; c++) begin
      tick();
      #1;
      vecs++;
      if ({mem_req_o, dm_ack_o, err_o} !== {1'b1, (c == 15), 1'b0}) begin
        errs++; $display("FAIL t4_cyc%0d: got req=%b ack=%b err=%b want 1 %b 0",
                         c, mem_req_o, dm_ack_o, err_o, (c == 15));
      end
    end
    tick();
    dm_req_i = 1'b0;
    #1;
    vecs++;
    if ({mem_req_o, dm_ack_o, err_o} !== 3'b001) begin
      errs++; $display("FAIL t4_cyc16: got %b want 001", {mem_req_o, dm_ack_o, err_o});
    end
    tick(); tick();
    vecs++;
    if (err_o !== 1'b1) begin
      errs++; $display("FAIL t4_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_reset_mid();
    if_req_i = 1'b1; if_addr_i = 32'h600;
    tick();
    #1;
    vecs++;
    if ({mem_req_o, sel_o, if_ack_o} !== 3'b100) begin
      errs++; $display("FAIL t5_gnt: got %b want 100", {mem_req_o, sel_o, if_ack_o});
    end
    tick();
    rst_i = 1'b1;
    #1;
    vecs++;
    if (if_ack_o !== 1'b0) begin
      errs++; $display("FAIL t5_no_ack: got %b want 0", if_ack_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    vecs++;
    if ({mem_req_o, err_o, if_ack_o} !== 3'b000) begin
      errs++; $display("FAIL t5_after_rst: got %b want 000", {mem_req_o, err_o, if_ack_o});
    end
    tick();
    mem_ack_i = 1'b1;
    #1;
    vecs++;
    if ({mem_req_o, sel_o, mem_addr_o, if_ack_o} !== {2'b10, 32'h600, 1'b1}) begin
      errs++; $display("FAIL t5_rearb: got req=%b sel=%b addr=%h ack=%b want 1 0 600 1",
                       mem_req_o, sel_o, mem_addr_o, if_ack_o);
    end
    tick();
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
  endtask

  task automatic test_idle_ack();
    mem_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      vecs++;
      if ({mem_req_o, if_ack_o, dm_ack_o, sel_o} !== 4'b0000) begin
        errs++; $display("FAIL t6_cyc%0d: got %b want 0000",
                         c, {mem_req_o, if_ack_o, dm_ack_o, sel_o});
      end
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_if_single();
    test_dm_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
